matmul_result_streamer: RTL

MATMUL_RESULT_STREAMER -- requirements
Module: matmul_result_streamer

---
 rtl/matmul_pkg.sv | 12 +
 rtl/matmul_result_streamer.sv | 99 +++++++++
 2 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matmul result streamer.
package matmul_pkg;
  localparam int N      = 8;   // matrix dimension
  localparam int ELEM_W = 16;  // packed result element width
  localparam int OUT_W  = 32;  // streamed word width
  localparam int IDX_W  = 6;   // {row, col} index width

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/matmul_result_streamer.sv
// Captures the NxN result matrix on a rising core_done and streams it out
// row-major, one sign-extended element per valid/ready handshake.
module matmul_result_streamer
  import matmul_pkg::*;
#(
  parameter int N      = matmul_pkg::N,
  parameter int ELEM_W = matmul_pkg::ELEM_W,
  parameter int OUT_W  = matmul_pkg::OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_done,
  input  logic [N*N*ELEM_W-1:0] c_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int              CW       = N*N*ELEM_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N*N-1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_done_q;
  logic [CW-1:0]       r_cap;
  logic [IDX_W-1:0]    r_idx;
  logic                r_overrun;

  logic                w_cap;
  logic                w_valid;
  logic                w_xfer;
  logic                w_at_last;
  logic                w_wrap;
  logic                w_load;
  logic                w_drop;
  logic [ELEM_W-1:0]   w_elem;

  // done_q resets to 1 so a done level held through reset is not an edge.
  assign w_cap     = core_done & ~r_done_q;
  assign w_valid   = (r_state == STREAM);
  assign w_xfer    = w_valid & out_ready;
  assign w_at_last = (r_idx == LAST_IDX);
  assign w_wrap    = w_xfer & w_at_last;
  // A capture is taken in IDLE, or exactly on the final transfer (no bubble).
  assign w_load    = w_cap & ((r_state == IDLE) | w_wrap);
  // Any other capture during a stream is dropped and flagged.
  assign w_drop    = w_cap & (r_state == STREAM) & ~w_wrap;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cap) w_state_nxt = STREAM;
      STREAM:  if (w_wrap && !w_cap) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture register, index counter, edge detector and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q  <= 1'b1;
      r_cap     <= '0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= core_done;
      if (w_load) begin
        r_cap <= c_flat;
        r_idx <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  // Output mux straight off the capture register, so words hold while stalled.
  assign w_elem    = r_cap[int'(r_idx)*ELEM_W +: ELEM_W];
  assign out_data  = {{(OUT_W-ELEM_W){w_elem[ELEM_W-1]}}, w_elem};
  assign out_index = r_idx;
  assign out_valid = w_valid;
  assign out_last  = w_valid & w_at_last;
  assign busy      = w_valid;
  assign overrun   = r_overrun;

endmodule
